// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neuron slice: neuron state encoding and
// default datapath constants used by the neuron, synapse and top level.
package snn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_INTEGRATE  = 2'd1,
    ST_REFRACTORY = 2'd2
  } lif_state_t;

  localparam int DEF_WIDTH          = 8;
  localparam int DEF_THRESHOLD      = 200;
  localparam int DEF_LEAK           = 1;
  localparam int DEF_V_RESET        = 0;
  localparam int DEF_REFRACT_CYCLES = 4;

endpackage

// File: rtl/lif_neuron_core_if.sv
// Stimulus/response bundle between the input driver and the LIF neuron.
interface lif_neuron_core_if
  import snn_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             enable;
  logic [WIDTH-1:0] current_in;
  logic             current_valid;
  logic             spike;
  logic [WIDTH-1:0] membrane;
  logic             refractory;
  logic [7:0]       spike_count;

  modport master (
    output enable, current_in, current_valid,
    input  spike, membrane, refractory, spike_count
  );

  modport slave (
    input  enable, current_in, current_valid,
    output spike, membrane, refractory, spike_count
  );

endinterface

// File: rtl/sat_add_leak.sv
// Membrane update datapath: saturating add of the gated input current,
// followed by a leak subtraction floored at zero.
module sat_add_leak
  import snn_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEAK  = DEF_LEAK
) (
  input  logic [WIDTH-1:0] membrane,
  input  logic [WIDTH-1:0] current,
  input  logic             valid,
  output logic [WIDTH-1:0] v
);

  localparam logic [WIDTH:0] MAX_V  = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] LEAK_W = (WIDTH+1)'(LEAK);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] sat;

  always_comb begin
    sum = {1'b0, membrane} + (valid ? {1'b0, current} : '0);
    sat = sum[WIDTH] ? MAX_V : sum;
    v   = (sat > LEAK_W) ? WIDTH'(sat - LEAK_W) : '0;
  end

endmodule

// File: rtl/lif_neuron_core.sv
// Leaky integrate-and-fire neuron: integrates input current, fires a one-cycle
// spike on threshold crossing, then sits out a fixed refractory period.
//
//   state         | meaning
//   --------------+-------------------------------------------------------
//   ST_IDLE       | after reset; first enabled edge wakes to integrate
//   ST_INTEGRATE  | accumulate current minus leak, fire at threshold
//   ST_REFRACTORY | input ignored, membrane pinned at V_RESET, timer runs
module lif_neuron_core
  import snn_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int THRESHOLD      = DEF_THRESHOLD,
  parameter int LEAK           = DEF_LEAK,
  parameter int V_RESET        = DEF_V_RESET,
  parameter int REFRACT_CYCLES = DEF_REFRACT_CYCLES
) (
  input logic              clk,
  input logic              reset,
  lif_neuron_core_if.slave nif
);

  localparam int CNT_W = (REFRACT_CYCLES < 2) ? 1 : $clog2(REFRACT_CYCLES + 1);
  localparam logic [CNT_W-1:0] REFRACT_W = CNT_W'(REFRACT_CYCLES);
  localparam logic [WIDTH-1:0] THRESH_W  = WIDTH'(THRESHOLD);
  localparam logic [WIDTH-1:0] VRESET_W  = WIDTH'(V_RESET);

  lif_state_t       state, state_n;
  logic [WIDTH-1:0] membrane, membrane_n;
  logic             spike, spike_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       spike_count, count_n;
  logic [WIDTH-1:0] v;

  sat_add_leak #(
    .WIDTH (WIDTH),
    .LEAK  (LEAK)
  ) u_sat_add_leak (
    .membrane (membrane),
    .current  (nif.current_in),
    .valid    (nif.current_valid),
    .v        (v)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      membrane    <= '0;
      spike       <= 1'b0;
      cnt         <= '0;
      spike_count <= '0;
    end else begin
      state       <= state_n;
      membrane    <= membrane_n;
      spike       <= spike_n;
      cnt         <= cnt_n;
      spike_count <= count_n;
    end
  end

  // Everything holds by default; a disabled cycle only clears the spike.
  always_comb begin
    state_n    = state;
    membrane_n = membrane;
    spike_n    = 1'b0;
    cnt_n      = cnt;
    count_n    = spike_count;
    if (nif.enable) begin
      case (state)
        ST_IDLE: begin
          state_n    = ST_INTEGRATE;
          membrane_n = '0;
        end
        ST_INTEGRATE: begin
          if (v >= THRESH_W) begin
            spike_n    = 1'b1;
            membrane_n = VRESET_W;
            count_n    = spike_count + 8'd1;
            if (REFRACT_CYCLES != 0) begin
              state_n = ST_REFRACTORY;
              cnt_n   = REFRACT_W;
            end
          end else begin
            membrane_n = v;
          end
        end
        ST_REFRACTORY: begin
          membrane_n = VRESET_W;
          cnt_n      = (cnt == '0) ? '0 : cnt - 1'b1;
          if (cnt_n == '0) state_n = ST_INTEGRATE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign nif.spike       = spike;
  assign nif.membrane    = membrane;
  assign nif.refractory  = (state == ST_REFRACTORY);
  assign nif.spike_count = spike_count;

endmodule

// File: tb/tb_lif_neuron_core.sv
// Self-checking bench for lif_neuron_core: directed tables, corner sequences
// and randomized stimulus against a behavioural reference model.
module tb_lif_neuron_core;

  localparam int P_THRESH  = 200;
  localparam int P_LEAK    = 1;
  localparam int P_VRESET  = 0;
  localparam int P_REFRACT = 4;

  bit   clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  lif_neuron_core_if #(.WIDTH(8)) nif ();
  lif_neuron_core_if #(.WIDTH(8)) sif ();

  lif_neuron_core dut (
    .clk   (clk),
    .reset (rst),
    .nif   (nif.slave)
  );

  lif_neuron_core #(
    .WIDTH          (8),
    .THRESHOLD      (255),
    .LEAK           (0),
    .V_RESET        (255),
    .REFRACT_CYCLES (0)
  ) dut_sat (
    .clk   (clk),
    .reset (rst),
    .nif   (sif.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model of the default neuron
  bit m_awake;
  int m_mem, m_left, m_count;
  bit m_spike;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_step(bit r, bit en, int cur, bit val);
    int s, v;
    if (r) begin
      m_awake = 0; m_mem = 0; m_spike = 0; m_left = 0; m_count = 0;
    end else if (!en) begin
      m_spike = 0;
    end else if (!m_awake) begin
      m_awake = 1; m_mem = 0; m_spike = 0;
    end else if (m_left > 0) begin
      m_left  = m_left - 1;
      m_mem   = P_VRESET;
      m_spike = 0;
    end else begin
      s = m_mem + (val ? cur : 0);
      if (s > 255) s = 255;
      v = (s > P_LEAK) ? s - P_LEAK : 0;
      if (v >= P_THRESH) begin
        m_spike = 1;
        m_mem   = P_VRESET;
        m_count = (m_count + 1) % 256;
        m_left  = P_REFRACT;
      end else begin
        m_mem   = v;
        m_spike = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step(rst, nif.enable, int'(nif.current_in), nif.current_valid);
    #1;
    check("model_membrane", int'(nif.membrane), m_mem);
    check("model_spike", int'(nif.spike), int'(m_spike));
    check("model_refractory", int'(nif.refractory), int'(m_left > 0));
    check("model_spike_count", int'(nif.spike_count), m_count);
  endtask

  task automatic drive(bit en, int cur, bit val);
    nif.enable        = en;
    nif.current_in    = 8'(cur);
    nif.current_valid = val;
  endtask

  task automatic expect_out(string tag, int mem, bit spk, bit refr, int cnt);
    check({tag, "_membrane"}, int'(nif.membrane), mem);
    check({tag, "_spike"}, int'(nif.spike), int'(spk));
    check({tag, "_refractory"}, int'(nif.refractory), int'(refr));
    check({tag, "_count"}, int'(nif.spike_count), cnt);
  endtask

  typedef struct {
    bit en;
    int cur;
    bit val;
    int mem;
    bit spk;
    bit refr;
    int cnt;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int seen;

    vecs[0]  = '{1, 51, 1,   0, 0, 0, 0};
    vecs[1]  = '{1, 51, 1,  50, 0, 0, 0};
    vecs[2]  = '{1, 51, 1, 100, 0, 0, 0};
    vecs[3]  = '{1, 51, 1, 150, 0, 0, 0};
    vecs[4]  = '{1, 51, 1,   0, 1, 1, 1};
    vecs[5]  = '{1, 51, 1,   0, 0, 1, 1};
    vecs[6]  = '{1, 51, 1,   0, 0, 1, 1};
    vecs[7]  = '{1, 51, 1,   0, 0, 1, 1};
    vecs[8]  = '{1, 51, 1,   0, 0, 0, 1};
    vecs[9]  = '{1, 51, 1,  50, 0, 0, 1};
    vecs[10] = '{1, 51, 1, 100, 0, 0, 1};
    vecs[11] = '{1, 51, 1, 150, 0, 0, 1};
    vecs[12] = '{1, 51, 1,   0, 1, 1, 2};

    rst = 1'b1;
    drive(1, 0, 0);
    sif.enable = 1'b0; sif.current_in = 8'd0; sif.current_valid = 1'b0;

    // reset held 3 cycles
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("reset", 0, 0, 0, 0);
    end
    rst = 1'b0;

    // saturation with THRESHOLD=255, LEAK=0, V_RESET=255, no refractory
    drive(0, 0, 0);
    sif.enable = 1'b1; sif.current_in = 8'd0; sif.current_valid = 1'b0;
    step();
    check("sat_wake_membrane", int'(sif.membrane), 0);
    sif.current_in = 8'd100; sif.current_valid = 1'b1;
    step();
    check("sat_100_membrane", int'(sif.membrane), 100);
    check("sat_100_spike", int'(sif.spike), 0);
    sif.current_in = 8'd255;
    step();
    check("sat_membrane", int'(sif.membrane), 255);
    check("sat_spike", int'(sif.spike), 1);
    check("sat_count", int'(sif.spike_count), 1);
    check("sat_refractory", int'(sif.refractory), 0);
    sif.current_valid = 1'b0;
    step();
    check("sat_refire_spike", int'(sif.spike), 1);
    check("sat_refire_count", int'(sif.spike_count), 2);
    sif.enable = 1'b0;

    // wake + periodic firing table
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].en, vecs[i].cur, vecs[i].val);
      step();
      expect_out($sformatf("vec%0d", i), vecs[i].mem, vecs[i].spk, vecs[i].refr, vecs[i].cnt);
    end

    // leak floors at zero without wrapping
    drive(1, 0, 0);
    for (int i = 0; i < 4; i++) step();
    check("leak_pre_refractory", int'(nif.refractory), 0);
    drive(1, 3, 1);
    step();
    expect_out("leak_load", 2, 0, 0, 2);
    drive(1, 0, 0);
    step(); expect_out("leak1", 1, 0, 0, 2);
    step(); expect_out("leak2", 0, 0, 0, 2);
    step(); expect_out("leak3", 0, 0, 0, 2);
    step(); expect_out("leak4", 0, 0, 0, 2);

    // freeze mid-refractory, then resume
    drive(1, 255, 1);
    step(); expect_out("frz_fire", 0, 1, 1, 3);
    drive(1, 0, 0);
    step(); expect_out("frz_ref1", 0, 0, 1, 3);
    drive(0, 255, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      expect_out("frz_hold", 0, 0, 1, 3);
    end
    drive(1, 255, 1);
    step(); expect_out("frz_res1", 0, 0, 1, 3);
    step(); expect_out("frz_res2", 0, 0, 1, 3);
    drive(1, 0, 0);
    step(); expect_out("frz_exit", 0, 0, 0, 3);

    // reset mid-refractory
    drive(1, 255, 1);
    step(); expect_out("rr_fire", 0, 1, 1, 4);
    step();
    rst = 1'b1;
    step(); expect_out("rr_reset", 0, 0, 0, 0);
    rst = 1'b0;
    step(); expect_out("rr_wake", 0, 0, 0, 0);

    // spike counter wrap
    seen = 0;
    for (int c = 0; c < 3000 && seen < 255; c++) begin
      step();
      if (nif.spike) seen++;
    end
    check("wrap_255_spikes_seen", seen, 255);
    check("wrap_count_255", int'(nif.spike_count), 255);
    for (int c = 0; c < 20 && seen < 256; c++) begin
      step();
      if (nif.spike) seen++;
    end
    check("wrap_256_spikes_seen", seen, 256);
    check("wrap_count_0", int'(nif.spike_count), 0);

    // randomized stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(99) < 2);
      drive($urandom_range(9) < 8, int'($urandom_range(255)) >> $urandom_range(3),
            $urandom_range(3) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
